sync_down_timer: RTL and testbench
==================================

Name: sync_down_timer

Overview:
- Synchronous, loadable down-counter/timer. It is the counting-down counterpart to the team's ripple up-counter.
- Counts a programmed value down to zero, one count per enabled clock. Flags terminal count and optionally auto-reloads to make periodic ticks.
- Used for timeouts, prescalers and periodic-event generation alongside the up-counter datapath.

Parameters:
WIDTH, 12, counter and load-value width in bits (minimum 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset; 0 clears all state immediately
load  input  1  synchronous load strobe
load_val  input  WIDTH  value captured on load into both q and reload register
start  input  1  begin counting from IDLE or DONE
stop  input  1  abort counting, return to IDLE holding q
en  input  1  count enable; q decrements only when 1
auto_reload  input  1  1 = periodic mode, 0 = one-shot
q  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse, one clk wide, registered
busy  output  1  1 while in RUN
done  output  1  1 while in DONE (one-shot expiry)

Behaviour:
- Reset (reset=0, async): q=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0. All are held while reset=0. Reset mid-RUN aborts with no tc.
- States: IDLE, RUN, DONE. busy=(state==RUN) and done=(state==DONE), both registered.
- tc defaults to 0 every cycle. It is asserted only on the edges listed below.
- Priority per edge: load > stop > start > count.
- load=1 (any state): q<=load_val, reload_reg<=load_val, state<=IDLE. start, stop and en are ignored that cycle.
- stop=1 (no load): state<=IDLE, q holds. Ignored in IDLE.
- start in IDLE:
  - if q!=0: state<=RUN.
  - if q==0: tc<=1, state<=DONE.
- start in DONE: q<=reload_reg.
  - if reload_reg!=0: state<=RUN.
  - else: tc<=1, stay DONE.
- start in RUN: ignored.
- RUN, en=0: q holds, no state change.
- RUN, en=1, q>1: q<=q-1.
- RUN, en=1, q==1, auto_reload=0: q<=0, tc<=1, state<=DONE.
- RUN, en=1, q==1, auto_reload=1: q<=reload_reg, tc<=1, stay RUN. This gives a tc period of exactly reload_reg enabled cycles.
- If auto_reload=1 and reload_reg==1: tc is asserted on every enabled cycle and q stays 1.
- q never wraps below 0. No decrement occurs outside RUN.
- auto_reload is sampled only on the q==1 edge. It may change freely at other times.
- Latency: tc and q update in the same edge. tc is high for exactly one cycle per expiry.
- Arithmetic is unsigned, modulo-free: a WIDTH-bit subtract of 1, guarded by the q!=0 rule.

Test Plan:
- Reset/load: reset=0 mid-RUN with q=0x123 -> q=0, busy=0, done=0, tc=0 asynchronously. Release, then load_val=0x005 with load -> q=5, state IDLE.
- One-shot: load 3, start, en=1 continuous -> q goes 3,2,1,0 on successive edges. tc is high one cycle together with q=0. done=1, busy=0 afterwards, and q stays 0.
- Periodic with gated enable: load 4, auto_reload=1, start, en toggled 1/0 -> q decrements only on en=1 edges. tc pulses every 4th enabled cycle and q reloads to 4 (never shows 0). busy stays 1.
- Zero/edge values:
  - load 0 then start -> tc one cycle, done=1, no RUN.
  - load 0xFFF, run 4095 enabled cycles -> tc exactly once, q=0.
  - reload 1 with auto_reload -> tc every enabled cycle.
- Priority collisions:
  - load+start same edge -> q=load_val, state IDLE, no RUN.
  - stop+start in RUN at q=7 -> IDLE with q=7.
  - start in RUN -> no effect.
  - start in DONE with reload 2 -> q=2, RUN, tc after 2 enabled cycles.

Source files
------------

// File: rtl/sync_down_timer.sv
// sync_down_timer
// Loadable synchronous down-counter/timer. A programmed value counts down to
// zero, one count per enabled clock. The block flags terminal count with a
// one-cycle tc pulse. In periodic mode it reloads automatically.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       asynchronous active-low reset, clears all state
//   load        synchronous load strobe (highest priority)
//   load_val    value captured into both q and the reload register on load
//   start       begin counting from IDLE or restart from DONE
//   stop        abort counting, return to IDLE with q held
//   en          count enable, q decrements only while high in RUN
//   auto_reload 1 = periodic (reload on expiry), 0 = one-shot
//   q           current count value (registered)
//   tc          terminal-count pulse, one clock wide (registered)
//   busy        high while in RUN (registered)
//   done        high while in DONE after a one-shot expiry (registered)
module sync_down_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;

    // Next-state decode. Each edge takes the first matching control in the
    // order load, stop, start, count. A stop always consumes its cycle, so a
    // start on the same edge is dropped even when stop has nothing to abort.
    always_comb begin
        state_next  = state;
        q_next      = q;
        reload_next = reload_reg;
        tc_next     = 1'b0;

        if (load) begin
            q_next      = load_val;
            reload_next = load_val;
            state_next  = IDLE;
        end else if (stop) begin
            if (state != IDLE) begin
                state_next = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (q != ZERO) begin
                            state_next = RUN;
                        end else begin
                            tc_next    = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        q_next = reload_reg;
                        if (reload_reg != ZERO) begin
                            state_next = RUN;
                        end else begin
                            tc_next = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A start while running has no effect, so counting goes on.
                    if (en) begin
                        if (q > ONE) begin
                            q_next = q - ONE;
                        end else if (q == ONE) begin
                            tc_next = 1'b1;
                            if (auto_reload) begin
                                q_next = reload_reg;
                            end else begin
                                q_next     = ZERO;
                                state_next = DONE;
                            end
                        end else begin
                            // RUN is never entered with q at zero. If it happens
                            // anyway, park in DONE rather than wrap.
                            state_next = DONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State registers. busy and done are decoded from the next state, so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q          <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
            busy       <= (state_next == RUN);
            done       <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer
// Self-checking bench for sync_down_timer with WIDTH=12. It applies a table
// of vectors, and the expected outputs for each vector go into a scoreboard
// queue. A few hand-written sequences cover asynchronous reset, the
// full-range count and the reset-release load.
module tb_sync_down_timer;

    localparam int W = 12;

    typedef struct packed {
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    typedef struct packed {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         sp;
        logic         en;
        logic         ar;
        exp_t         e;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    int   errors;
    int   checks;
    exp_t sb[$];
    vec_t vecs[$];

    sync_down_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one value and counts the result
    task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic st,
                                input logic sp, input logic e, input logic ar,
                                input logic [W-1:0] eq, input logic etc,
                                input logic eb, input logic ed);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.en = e; v.ar = ar;
        v.e.q = eq; v.e.tc = etc; v.e.busy = eb; v.e.done = ed;
        return v;
    endfunction

    // Drives one vector away from the active edge and queues its expectation
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        load        = v.ld;
        load_val    = v.lv;
        start       = v.st;
        stop        = v.sp;
        en          = v.en;
        auto_reload = v.ar;
        sb.push_back(v.e);
    endtask

    // Samples after the edge and checks against the oldest expectation
    task automatic checkOutput(input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty[%0d]: got 0 expected 1 entries", idx);
        end else begin
            e = sb.pop_front();
            compare($sformatf("v%0d.q", idx), q, e.q);
            compare($sformatf("v%0d.tc", idx), W'(tc), W'(e.tc));
            compare($sformatf("v%0d.busy", idx), W'(busy), W'(e.busy));
            compare($sformatf("v%0d.done", idx), W'(done), W'(e.done));
        end
    endtask

    task automatic idleInputs();
        load = 0; load_val = '0; start = 0; stop = 0; en = 0; auto_reload = 0;
    endtask

    initial begin
        int tcCount;
        errors = 0;
        checks = 0;
        idleInputs();
        reset = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare("reset.q", q, '0);
        compare("reset.tc", W'(tc), '0);
        compare("reset.busy", W'(busy), '0);
        compare("reset.done", W'(done), '0);
        @(negedge clk);
        reset = 1'b1;

        //          ld lv       st sp en ar   q        tc b  d
        vecs.push_back(mk(1, 12'h005, 0, 0, 0, 0, 12'h005, 0, 0, 0));
        // one-shot from 3
        vecs.push_back(mk(1, 12'h003, 0, 0, 0, 0, 12'h003, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 1, 0, 12'h003, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h002, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h001, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h000, 1, 0, 1));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h000, 0, 0, 1));
        // periodic from 4 with gated enable
        vecs.push_back(mk(1, 12'h004, 0, 0, 0, 1, 12'h004, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 1, 12'h004, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h003, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 1, 12'h003, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h002, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 1, 12'h002, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h001, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h004, 1, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h003, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1, 0, 1, 12'h003, 0, 0, 0));
        // zero load then start, and restart from DONE with zero reload
        vecs.push_back(mk(1, 12'h000, 0, 0, 0, 0, 12'h000, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h000, 1, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h000, 1, 0, 1));
        // reload of 1 in periodic mode
        vecs.push_back(mk(1, 12'h001, 0, 0, 0, 1, 12'h001, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 1, 12'h001, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h001, 1, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 1, 12'h001, 1, 1, 0));
        // load and start on the same edge
        vecs.push_back(mk(1, 12'h009, 1, 0, 1, 0, 12'h009, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h009, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h008, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h007, 0, 1, 0));
        // stop and start together in RUN at q=7
        vecs.push_back(mk(0, 12'h000, 1, 1, 1, 0, 12'h007, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h007, 0, 1, 0));
        // start while running
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h007, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 1, 0, 12'h006, 0, 1, 0));
        // restart from DONE with reload 2
        vecs.push_back(mk(1, 12'h002, 0, 0, 0, 0, 12'h002, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h002, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h001, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h000, 1, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 12'h002, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h001, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 12'h000, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end
        compare("scoreboard_drained", W'(sb.size()), '0);

        // Full-range count: 0xFFF takes 4095 enabled cycles to reach zero
        @(negedge clk);
        idleInputs();
        load = 1; load_val = 12'hFFF;
        @(negedge clk);
        load = 0; start = 1;
        @(negedge clk);
        start = 0; en = 1;
        tcCount = 0;
        for (int i = 0; i < 4095; i++) begin
            @(posedge clk);
            #1;
            if (tc) tcCount++;
        end
        compare("fullrange.q", q, '0);
        compare("fullrange.tc_count", W'(tcCount), W'(1));
        compare("fullrange.done", W'(done), W'(1));
        compare("fullrange.busy", W'(busy), '0);

        // Asynchronous reset while running at 0x123
        @(negedge clk);
        idleInputs();
        load = 1; load_val = 12'h123;
        @(negedge clk);
        load = 0; start = 1;
        @(negedge clk);
        start = 0;
        compare("prereset.busy", W'(busy), W'(1));
        compare("prereset.q", q, 12'h123);
        #2;
        reset = 1'b0;
        #1;
        compare("asyncreset.q", q, '0);
        compare("asyncreset.busy", W'(busy), '0);
        compare("asyncreset.done", W'(done), '0);
        compare("asyncreset.tc", W'(tc), '0);
        @(negedge clk);
        reset = 1'b1;
        load = 1; load_val = 12'h005;
        @(posedge clk);
        #1;
        compare("postreset.q", q, 12'h005);
        compare("postreset.busy", W'(busy), '0);
        compare("postreset.done", W'(done), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
